// File: rtl/lfsr_rng_bounded.sv
// lfsr_rng_bounded: Fibonacci LFSR random source with rejection sampling against an exclusive bound.
module lfsr_rng_bounded #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] SEED = 8'h80,
  parameter int MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic [WIDTH-1:0] bound,
  output logic             ready,
  output logic             rand_valid,
  output logic [WIDTH-1:0] rand_num,
  output logic             fail,
  input  logic             rand_ack
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [1:0] IDLE = 2'd0, STEP = 2'd1, HOLD = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] lfsr, bound_q, cand;
  logic [TW-1:0] tries;
  logic hit, last;
  assign cand = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
  assign hit = (bound_q == '0) || (cand < bound_q);
  assign last = tries == TW'(MAX_TRIES - 1);
  assign ready = state == IDLE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      lfsr <= SEED;
      bound_q <= '0;
      tries <= '0;
      rand_num <= '0;
      rand_valid <= 1'b0;
      fail <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (seed_load) lfsr <= (seed == '0) ? SEED : seed;
          else if (req) begin
            bound_q <= bound;
            tries <= '0;
            state <= STEP;
          end
        end
        STEP: begin
          lfsr <= cand;
          if (hit) begin
            rand_num <= cand;
            rand_valid <= 1'b1;
            fail <= 1'b0;
            state <= HOLD;
          end else begin
            tries <= tries + 1'b1;
            // Exhausting the budget still produces a result, flagged by fail.
            if (last) begin
              rand_num <= '0;
              fail <= 1'b1;
              rand_valid <= 1'b1;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (rand_ack) begin
            rand_valid <= 1'b0;
            fail <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lfsr_rng_bounded.sv
// tb_lfsr_rng_bounded: directed vectors with a scoreboard queue drained by a monitor on valid.
module tb_lfsr_rng_bounded;
  logic clk = 1'b0, reset_n, seed_load = 1'b0, req = 1'b0, rand_ack = 1'b0;
  logic [7:0] seed = '0, bound = '0, rand_num;
  logic ready, rand_valid, fail;
  int checks = 0, errors = 0;
  logic [8:0] sb[$];
  logic seen_valid = 1'b0;
  logic seen[256];
  lfsr_rng_bounded dut (
    .clk(clk), .reset_n(reset_n), .seed_load(seed_load), .seed(seed), .req(req),
    .bound(bound), .ready(ready), .rand_valid(rand_valid), .rand_num(rand_num),
    .fail(fail), .rand_ack(rand_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rand_valid && !seen_valid) begin
      seen_valid = 1'b1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got num=0x%0h fail=%0b, expected none", rand_num, fail);
      end else chk("result", {fail, rand_num}, sb.pop_front());
    end else if (!rand_valid) seen_valid = 1'b0;
  end
  function automatic logic [7:0] model_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction
  task automatic load_seed(input logic [7:0] v);
    @(posedge clk); #1;
    seed_load = 1'b1; seed = v;
    @(posedge clk); #1;
    seed_load = 1'b0;
  endtask
  task automatic txn(input logic [7:0] b, input logic [7:0] en, input logic ef,
                     input int elat, input int hold, output logic [7:0] got);
    int lat;
    lat = 0;
    got = '0;
    @(posedge clk); #1;
    req = 1'b1; bound = b;
    sb.push_back({ef, en});
    @(posedge clk); #1;
    req = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (rand_valid) begin lat = n; break; end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no rand_valid in 40 cycles, expected latency %0d", elat);
      void'(sb.pop_back());
      return;
    end
    if (elat > 0) chk("latency", lat, elat);
    got = rand_num;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", rand_valid, 1'b1);
      chk("hold_num", rand_num, en);
    end
    rand_ack = 1'b1;
    @(posedge clk); #1;
    rand_ack = 1'b0;
    chk("ack_clears_valid", rand_valid, 1'b0);
  endtask
  initial begin
    logic [7:0] g, m;
    int dup;
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_ready", ready, 1'b1);
    chk("async_reset_valid", rand_valid, 1'b0);
    chk("async_reset_num", rand_num, 8'h00);
    chk("async_reset_fail", fail, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    txn(8'h00, 8'h01, 1'b0, 1, 0, g);
    txn(8'h00, 8'h02, 1'b0, 1, 10, g);
    txn(8'h00, 8'h04, 1'b0, 1, 0, g);
    load_seed(8'h47);
    txn(8'h1D, 8'h1C, 1'b0, 2, 0, g);
    load_seed(8'h08);
    txn(8'h11, 8'h00, 1'b1, 16, 0, g);
    txn(8'h00, 8'hB8, 1'b0, 1, 0, g);
    @(posedge clk); #1;
    seed_load = 1'b1; seed = 8'h00; req = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0; req = 1'b0;
    chk("seed_prio_ready", ready, 1'b1);
    chk("zero_seed_lfsr", dut.lfsr, 8'h80);
    txn(8'h00, 8'h01, 1'b0, 1, 0, g);
    load_seed(8'h08);
    @(posedge clk); #1;
    req = 1'b1; bound = 8'h11;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_valid", rand_valid, 1'b0);
    chk("abort_ready", ready, 1'b1);
    chk("abort_lfsr", dut.lfsr, 8'h80);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    foreach (seen[i]) seen[i] = 1'b0;
    dup = 0;
    m = 8'h80;
    for (int i = 0; i < 255; i++) begin
      m = model_next(m);
      txn(8'h00, m, 1'b0, 1, 0, g);
      if (seen[g]) dup++;
      seen[g] = 1'b1;
    end
    chk("period_distinct_dups", dup, 0);
    chk("period_last", g, 8'h80);
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
